prbs_gen: RTL
=============

PRBS_GEN -- requirements
Module: prbs_gen

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning word width and LFSR length.
REQ-002 The block SHALL have parameter TAP1, default 6, meaning the first feedback tap index.
REQ-003 The block SHALL have parameter TAP2, default 5, meaning the second feedback tap index.
REQ-004 The block SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset  input  1  meaning reset; it is asynchronous and active-low.
REQ-006 The block SHALL have port en  input  1  meaning advance the sequence one word this cycle.
REQ-007 The block SHALL have port seed_load  input  1  meaning load seed into the LFSR this cycle.
REQ-008 The block SHALL have port seed  input  WIDTH  meaning the LFSR load value.
REQ-009 The block SHALL have port inj_req  input  1  meaning a one-cycle request to start an error-injection burst.
REQ-010 The block SHALL have port inj_mask  input  WIDTH  meaning the bits XORed into each corrupted word.
REQ-011 The block SHALL have port inj_num  input  8  meaning the number of words to corrupt per burst.
REQ-012 The block SHALL have port inj_gap  input  8  meaning the number of clean words between corrupted words.
REQ-013 The block SHALL have port prbs  output  WIDTH  meaning the registered PRBS word.
REQ-014 The block SHALL have port valid  output  1  meaning prbs was updated this cycle.
REQ-015 The block SHALL have port inj_busy  output  1  meaning a burst is in progress.
REQ-016 The block SHALL have port inj_total  output  16  meaning the saturating count of corrupted words since reset.

Function
REQ-017 The LFSR SHALL advance by exactly WIDTH single-bit steps per enabled cycle; each step is state = {state[WIDTH-2:0], state[TAP1]^state[TAP2]}.
REQ-018 With en=1 and seed_load=0 in cycle N, the LFSR SHALL hold the advanced value after edge N, and prbs SHALL equal that value XOR the current mask in the same edge (latency 1).
REQ-019 The current mask SHALL be inj_mask while the FSM is in INJECT, and 0 otherwise.
REQ-020 Injection SHALL corrupt only prbs; the LFSR state itself SHALL never be corrupted.
REQ-021 valid SHALL be the registered en; when en=0, prbs, the LFSR and the FSM SHALL hold.
REQ-022 seed_load SHALL take priority over en; the LFSR SHALL load seed and prbs SHALL hold for that cycle.
REQ-023 A seed of all zeros SHALL be replaced by 1 to avoid lock-up.
REQ-024 The injection FSM SHALL have the states IDLE, INJECT and GAP.
REQ-025 IDLE -> INJECT SHALL occur when inj_req=1 and inj_num!=0; inj_num, inj_gap and inj_mask SHALL be captured at that point.
REQ-026 If inj_req=1 and inj_num=0, the FSM SHALL stay in IDLE.
REQ-027 In INJECT, each enabled cycle SHALL emit one corrupted word and decrement the remaining count.
REQ-028 When the last corrupted word is emitted, the FSM SHALL go to IDLE; otherwise it SHALL go to GAP when gap!=0, or stay in INJECT when gap=0.
REQ-029 GAP SHALL count gap enabled cycles of clean words, then return to INJECT.
REQ-030 inj_req while inj_busy=1 SHALL be ignored (no restart, no queueing).
REQ-031 inj_busy SHALL be 1 in INJECT and GAP.
REQ-032 inj_total SHALL increment per corrupted word and saturate at 16'hFFFF.
REQ-033 seed_load during a burst SHALL NOT alter the FSM.

Reset
REQ-034 On reset low, the block SHALL asynchronously set: LFSR=1, prbs=0, valid=0, FSM=IDLE, inj_busy=0, inj_total=0, and all captured counts, gap and mask to 0.
REQ-035 Reset asserted mid-burst SHALL abort the burst with no further corrupted words.
REQ-036 Release of reset SHALL be synchronised externally; the first enabled edge after release SHALL advance from the seed value 1.

Verification
REQ-037 Bench SHALL check: defaults, reset release, en=1 for 2 cycles -> prbs=8'h06 then 8'h14, valid=1 both cycles.
REQ-038 Bench SHALL check: en toggling 1,0,1 -> prbs holds during the en=0 cycle, and the sequence is identical to the continuous-en sequence.
REQ-039 Bench SHALL check: seed_load with seed=0, then en -> first word 8'h06 (zero-seed replaced by 1).
REQ-040 Bench SHALL check: inj_req with mask=8'h01, num=3, gap=2 -> words 1,4,7 of the burst differ from the golden model only in bit 0, inj_total=3, and inj_busy falls after word 7.
REQ-041 Bench SHALL check: a second inj_req mid-burst -> ignored, inj_total=3.
REQ-042 Bench SHALL check: reset pulse mid-burst -> inj_busy=0 immediately, prbs=0, and post-release output is clean from 8'h06.
REQ-043 Bench SHALL check: loopback into the existing checker with mask=8'h07, num=1 -> checker lock drops, then re-locks within 3 words.

Source files
------------

// File: rtl/prbs_gen_if.sv
// PRBS generator bus: control, seed and error-injection inputs travel
// from the master (stimulus side) to the slave (generator); the PRBS
// word, its valid strobe and the injection status travel back.
interface prbs_gen_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             seed_load;
  logic [WIDTH-1:0] seed;
  logic             inj_req;
  logic [WIDTH-1:0] inj_mask;
  logic [7:0]       inj_num;
  logic [7:0]       inj_gap;
  logic [WIDTH-1:0] prbs;
  logic             valid;
  logic             inj_busy;
  logic [15:0]      inj_total;

  modport master (
    output en, seed_load, seed, inj_req, inj_mask, inj_num, inj_gap,
    input  prbs, valid, inj_busy, inj_total
  );

  modport slave (
    input  en, seed_load, seed, inj_req, inj_mask, inj_num, inj_gap,
    output prbs, valid, inj_busy, inj_total
  );
endinterface

// File: rtl/prbs_gen.sv
// Word-wide PRBS generator with a programmable error-injection burst.
// The LFSR advances WIDTH single-bit steps per enabled cycle. Injection
// only XORs a mask into the output word; the LFSR itself stays clean so
// the stream resynchronises right after a corrupted word.
module prbs_gen #(
  parameter int WIDTH = 8,
  parameter int TAP1  = 6,
  parameter int TAP2  = 5
) (
  input  logic      clk,
  input  logic      reset,
  prbs_gen_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    INJECT = 2'd1,
    GAP    = 2'd2
  } inj_state_t;

  logic [WIDTH-1:0] lfsr_reg;
  logic [WIDTH-1:0] prbs_reg;
  logic             valid_reg;
  inj_state_t       state_reg;
  logic             busy_reg;
  logic [7:0]       num_reg;
  logic [7:0]       gap_cfg_reg;
  logic [7:0]       gap_cnt_reg;
  logic [WIDTH-1:0] mask_reg;
  logic [15:0]      total_reg;

  logic [WIDTH-1:0] step_chain [0:WIDTH];
  logic [WIDTH-1:0] lfsr_next;
  logic [WIDTH-1:0] cur_mask;
  logic             word_adv;

  // A word is emitted only when enabled and not overridden by a seed load.
  assign word_adv = bus.en & ~bus.seed_load;

  // Chain of WIDTH single-bit LFSR steps producing the next word.
  assign step_chain[0] = lfsr_reg;
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_step
      assign step_chain[gi+1] = {step_chain[gi][WIDTH-2:0],
                                 step_chain[gi][TAP1] ^ step_chain[gi][TAP2]};
    end
  endgenerate
  assign lfsr_next = step_chain[WIDTH];

  // Corruption applies only while the FSM sits in INJECT.
  assign cur_mask = (state_reg == INJECT) ? mask_reg : '0;

  // LFSR, output word and valid strobe; a zero seed is replaced by 1 so
  // the register can never lock up.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_reg  <= {{(WIDTH-1){1'b0}}, 1'b1};
      prbs_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= word_adv;
      if (bus.seed_load) begin
        lfsr_reg <= (bus.seed == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : bus.seed;
      end else if (bus.en) begin
        lfsr_reg <= lfsr_next;
        prbs_reg <= lfsr_next ^ cur_mask;
      end
    end
  end

  // Injection FSM: IDLE waits for a request, INJECT corrupts one word per
  // emitted word, GAP lets the configured number of clean words through.
  // Requests arriving while busy are dropped; seed loads emit no word and
  // therefore never move the FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      busy_reg    <= 1'b0;
      num_reg     <= 8'd0;
      gap_cfg_reg <= 8'd0;
      gap_cnt_reg <= 8'd0;
      mask_reg    <= '0;
      total_reg   <= 16'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.inj_req && (bus.inj_num != 8'd0)) begin
            state_reg   <= INJECT;
            busy_reg    <= 1'b1;
            num_reg     <= bus.inj_num;
            gap_cfg_reg <= bus.inj_gap;
            mask_reg    <= bus.inj_mask;
          end
        end
        INJECT: begin
          if (word_adv) begin
            if (total_reg != 16'hFFFF) begin
              total_reg <= total_reg + 16'd1;
            end
            if (num_reg == 8'd1) begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
              num_reg   <= 8'd0;
            end else begin
              num_reg <= num_reg - 8'd1;
              if (gap_cfg_reg != 8'd0) begin
                state_reg   <= GAP;
                gap_cnt_reg <= gap_cfg_reg;
              end
            end
          end
        end
        GAP: begin
          if (word_adv) begin
            if (gap_cnt_reg <= 8'd1) begin
              state_reg   <= INJECT;
              gap_cnt_reg <= 8'd0;
            end else begin
              gap_cnt_reg <= gap_cnt_reg - 8'd1;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.prbs      = prbs_reg;
  assign bus.valid     = valid_reg;
  assign bus.inj_busy  = busy_reg;
  assign bus.inj_total = total_reg;

endmodule
